// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller. Decodes per-stage enables and flushes
// from the current hazard inputs. Tracks data-memory waits to raise a sticky
// timeout flag, and counts stall cycles in a saturating counter.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_tkn,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_enable,
  output logic             fd_enable,
  output logic             de_enable,
  output logic             fd_flush,
  output logic             de_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]      state;
  logic [WC_W-1:0] wait_cnt;
  logic            freeze;
  logic            load_use;

  assign freeze   = mem_req && !mem_ready;
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == de_rs1) || (ex_rd == de_rs2));

  // Prioritised enable/flush decode: a frozen pipe never takes a flush, and a
  // taken branch outranks load-use because the stalled instruction is squashed.
  always_comb begin
    pc_enable = 1'b1;
    fd_enable = 1'b1;
    de_enable = 1'b1;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    if (freeze) begin
      pc_enable = 1'b0;
      fd_enable = 1'b0;
      de_enable = 1'b0;
    end else if (ex_branch_tkn) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (load_use) begin
      pc_enable = 1'b0;
      fd_enable = 1'b0;
      de_flush  = 1'b1;
    end
  end

  // Memory-wait tracking. The wait counter stops at its last value, so the
  // timeout flag keeps being re-asserted for as long as the wait lasts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        default: begin
          if (!freeze) begin
            state <= RUN;
          end else if (wait_cnt == WC_LAST) begin
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (!pc_enable && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, followed by randomized traffic. A behavioural model tracks
// the expected outputs and one compare process checks every cycle.
module tb_hazard_ctrl;
  localparam int MT   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    de_rs1, de_rs2, ex_rd;
  logic          ex_memread, ex_branch_tkn, mem_req, mem_ready;
  logic          pc_enable, fd_enable, de_enable, fd_flush, de_flush;
  logic [CW-1:0] stall_count;
  logic          mem_timeout;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .de_rs1(de_rs1), .de_rs2(de_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_tkn(ex_branch_tkn),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_enable(pc_enable), .fd_enable(fd_enable), .de_enable(de_enable),
    .fd_flush(fd_flush), .de_flush(de_flush),
    .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: consecutive frozen cycles, timeout flag, stall count.
  int m_run  = 0;
  int m_cnt  = 0;
  bit m_to   = 1'b0;
  bit chk_en = 1'b0;

  // Expected combinational outputs as {pc,fd,de,fd_flush,de_flush}.
  function automatic logic [4:0] exp_ctl();
    bit fr, lu;
    fr = mem_req && !mem_ready;
    lu = ex_memread && ex_rd != 0 && (ex_rd == de_rs1 || ex_rd == de_rs2);
    if (fr)            return 5'b000_00;
    if (ex_branch_tkn) return 5'b111_11;
    if (lu)            return 5'b001_01;
    return 5'b111_00;
  endfunction

  always @(posedge clk) begin
    logic [4:0] e;
    e = exp_ctl();
    if (!rst) begin
      m_run = 0; m_cnt = 0; m_to = 1'b0; chk_en = 1'b1;
    end else if (chk_en) begin
      if (mem_req && !mem_ready) begin
        m_run++;
        // The first frozen cycle is spent in RUN; wait cycle k is frozen
        // cycle k+1, and the flag sets at the end of wait cycle MT.
        if (m_run >= MT + 1) m_to = 1'b1;
      end else begin
        m_run = 0;
      end
      if (!e[4] && m_cnt < CMAX) m_cnt++;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] e, a;
      e = exp_ctl();
      a = {pc_enable, fd_enable, de_enable, fd_flush, de_flush};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ctl t=%0t got=%b exp=%b", $time, a, e);
      end
      checks++;
      if (stall_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, stall_count, m_cnt);
      end
      checks++;
      if (mem_timeout !== m_to) begin
        failures++;
        $display("FAIL mem_timeout t=%0t got=%b exp=%b", $time, mem_timeout, m_to);
      end
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    de_rs1 = 0; de_rs2 = 0; ex_rd = 0; ex_memread = 0;
    ex_branch_tkn = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; cyc(2); rst = 1'b1;
  endtask

  initial begin
    idle(); rst = 1'b0;
    // T1 reset
    cyc(2); rst = 1'b1; #1;
    lit("t1_ctl", {pc_enable, fd_enable, de_enable, fd_flush, de_flush}, 5'b11100);
    lit("t1_cnt", stall_count, 0);
    lit("t1_to", mem_timeout, 0);

    // T2 load-use, then the same with rd=x0
    ex_memread = 1; ex_rd = 5; de_rs2 = 5; #1;
    lit("t2_ctl", {pc_enable, fd_enable, de_enable, fd_flush, de_flush}, 5'b00101);
    cyc(); ex_rd = 0; de_rs2 = 0; #1;
    lit("t2_x0_ctl", {pc_enable, fd_enable, de_enable, fd_flush, de_flush}, 5'b11100);
    cyc(); idle();
    lit("t2_cnt", stall_count, 1);

    // T3 branch together with a load-use hazard
    ex_memread = 1; ex_rd = 7; de_rs1 = 7; ex_branch_tkn = 1; #1;
    lit("t3_ctl", {pc_enable, fd_enable, de_enable, fd_flush, de_flush}, 5'b11111);
    cyc(); idle();
    lit("t3_cnt", stall_count, 1);

    // T4 three-cycle memory wait with a branch pending during the wait
    do_reset();
    mem_req = 1; mem_ready = 0; ex_branch_tkn = 1; #1;
    lit("t4_frozen", {pc_enable, fd_enable, de_enable, fd_flush, de_flush}, 5'b00000);
    cyc(3); mem_ready = 1; #1;
    lit("t4_release", {pc_enable, fd_enable, de_enable, fd_flush, de_flush}, 5'b11111);
    lit("t4_cnt", stall_count, 3);
    cyc(); idle();
    lit("t4_cnt_after", stall_count, 3);

    // T5 timeout: flag appears after the 4th wait cycle (5th frozen cycle)
    do_reset();
    mem_req = 1; mem_ready = 0;
    cyc(4);
    lit("t5_before", mem_timeout, 0);
    cyc();
    lit("t5_set", mem_timeout, 1);
    cyc(5); mem_ready = 1; cyc(); idle(); cyc(3);
    lit("t5_sticky", mem_timeout, 1);
    do_reset(); #1;
    lit("t5_cleared", mem_timeout, 0);

    // T6 saturation
    mem_req = 1; cyc(20); idle(); #1;
    lit("t6_sat", stall_count, CMAX);
    do_reset();

    // Randomized traffic, biased toward hazards
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      de_rs1        = 5'($urandom_range(0, 3));
      de_rs2        = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_memread    = ($urandom_range(0, 99) < 40);
      ex_branch_tkn = ($urandom_range(0, 99) < 15);
      mem_req       = ($urandom_range(0, 99) < 35);
      mem_ready     = ($urandom_range(0, 99) < ((i % 100) < 50 ? 50 : 10));
      cyc();
    end
    rst = 1'b1; idle(); cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
